// File: rtl/button_debouncer.sv
// button_debouncer: conditions raw push-button pins for the 16 MHz domain.
// Each channel is normalised to pressed = 1, passed through a 2-flop
// synchroniser, then filtered by a stability counter. The outputs are a clean
// registered level plus one-cycle press/release strobes per channel.
module button_debouncer #(
    parameter int NBUTTONS        = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NBUTTONS-1:0] i_buttons,
    output logic [NBUTTONS-1:0] o_buttons,
    output logic [NBUTTONS-1:0] o_pressed,
    output logic [NBUTTONS-1:0] o_released
);

    // A single-cycle threshold still needs a 1-bit counter to keep the
    // arithmetic well formed; it simply never leaves zero.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NBUTTONS-1:0] btn_norm;
    logic [NBUTTONS-1:0] sync_q1;
    logic [NBUTTONS-1:0] sync_q2;
    logic [CNT_W-1:0]    cnt_q [NBUTTONS];

    // Normalise polarity so that pressed always reads as 1 downstream.
    assign btn_norm = ACTIVE_LOW ? ~i_buttons : i_buttons;

    // Two-flop synchroniser bringing the asynchronous pins into i_clk.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync_q2 take the old sync_q1,
            // giving two real flop stages instead of collapsing into one.
            sync_q1 <= btn_norm;
            sync_q2 <= sync_q1;
        end
    end

    // Per-channel stability counter: accept a new level only after it has
    // differed from the current state for DEBOUNCE_CYCLES evaluations in a row.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the counter array is a handful of flops, not a RAM, so it is
            // cleared here; a partial count must not survive a reset.
            for (int i = 0; i < NBUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
            o_buttons  <= '0;
            o_pressed  <= '0;
            o_released <= '0;
        end else begin
            for (int i = 0; i < NBUTTONS; i++) begin
                // Strobes default low so each one lasts exactly one cycle.
                o_pressed[i]  <= 1'b0;
                o_released[i] <= 1'b0;
                if (sync_q2[i] == o_buttons[i]) begin
                    // Any return to the current level discards the partial count.
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    o_buttons[i]  <= sync_q2[i];
                    cnt_q[i]      <= '0;
                    o_pressed[i]  <= sync_q2[i];
                    o_released[i] <= ~sync_q2[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: a 2-channel active-low instance with a
// 4-cycle threshold, and a 1-channel active-high instance with a 1-cycle
// threshold. Expected values are hand-derived from the edge k + D + 1 rule.
module tb_button_debouncer;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn;
    logic [1:0] dbn;
    logic [1:0] prs;
    logic [1:0] rls;

    logic       btn2;
    logic       dbn2;
    logic       prs2;
    logic       rls2;

    int checks;
    int failures;

    button_debouncer #(
        .NBUTTONS        (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_buttons  (btn),
        .o_buttons  (dbn),
        .o_pressed  (prs),
        .o_released (rls)
    );

    button_debouncer #(
        .NBUTTONS        (1),
        .DEBOUNCE_CYCLES (1),
        .ACTIVE_LOW      (1'b0)
    ) dut_fast (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_buttons  (btn2),
        .o_buttons  (dbn2),
        .o_pressed  (prs2),
        .o_released (rls2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn      = 2'b00;
        btn2     = 1'b0;

        // Reset with both buttons held: everything stays cleared.
        repeat (3) tick();
        check("rst_level", dbn, 2'b00);
        check("rst_press", prs, 2'b00);
        check("rst_release", rls, 2'b00);

        // Release reset between edges: first post-reset edge is k = 1,
        // so both channels flip on edge 6.
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_level_e5", dbn, 2'b00);
        check("post_rst_press_e5", prs, 2'b00);
        tick();
        check("post_rst_level_e6", dbn, 2'b11);
        check("post_rst_press_e6", prs, 2'b11);
        tick();
        check("post_rst_press_e7", prs, 2'b00);
        check("post_rst_level_e7", dbn, 2'b11);

        // Simultaneous release of both channels.
        btn = 2'b11;
        repeat (5) tick();
        check("rel_level_k4", dbn, 2'b11);
        check("rel_strobe_k4", rls, 2'b00);
        tick();
        check("rel_level_k5", dbn, 2'b00);
        check("rel_strobe_k5", rls, 2'b11);
        check("rel_no_press", prs, 2'b00);
        tick();
        check("rel_strobe_k6", rls, 2'b00);

        // Clean press on channel 0 only.
        btn = 2'b10;
        repeat (5) tick();
        check("press_level_k4", dbn, 2'b00);
        tick();
        check("press_level_k5", dbn, 2'b01);
        check("press_strobe_k5", prs, 2'b01);
        check("press_no_release", rls, 2'b00);
        tick();
        check("press_strobe_k6", prs, 2'b00);
        check("press_level_k6", dbn, 2'b01);

        // Release channel 0 to return to idle.
        btn = 2'b11;
        repeat (6) tick();
        check("rel0_level", dbn, 2'b00);
        check("rel0_strobe", rls, 2'b01);
        tick();

        // Bounce: pressed 3 cycles, released 1, then pressed steadily.
        btn = 2'b10;
        repeat (3) tick();
        check("bounce_press_a", prs, 2'b00);
        btn = 2'b11;
        tick();
        check("bounce_press_b", prs, 2'b00);
        btn = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bounce_wait_press", prs, 2'b00);
            check("bounce_wait_level", dbn, 2'b00);
        end
        tick();
        check("bounce_level", dbn, 2'b01);
        check("bounce_press", prs, 2'b01);

        // Back to idle.
        btn = 2'b11;
        repeat (6) tick();
        check("rel1_level", dbn, 2'b00);
        tick();

        // Mid-count reset: two counted cycles, then reset with the pin held.
        btn = 2'b10;
        repeat (4) tick();
        check("mid_before_rst", dbn, 2'b00);
        check("mid_no_strobe", prs, 2'b00);
        rst_n = 1'b0;
        repeat (2) tick();
        check("mid_in_rst", dbn, 2'b00);
        rst_n = 1'b1;
        repeat (5) tick();
        check("mid_wait_press", prs, 2'b00);
        check("mid_wait_level", dbn, 2'b00);
        tick();
        check("mid_press", prs, 2'b01);
        check("mid_level", dbn, 2'b01);
        tick();

        // Reset while pressed: level drops at once, no release strobe.
        rst_n = 1'b0;
        #1;
        check("rst_held_level", dbn, 2'b00);
        check("rst_held_release", rls, 2'b00);
        btn = 2'b11;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("rst_held_after", dbn, 2'b00);
        check("rst_held_no_rel", rls, 2'b00);

        // Fast instance: a glitch between edges is never sampled.
        #2 btn2 = 1'b1;
        #2 btn2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("glitch_level", {1'b0, dbn2}, 2'b00);
            check("glitch_press", {1'b0, prs2}, 2'b00);
        end

        // Fast instance: 0 -> 1 accepted two edges after first sample.
        btn2 = 1'b1;
        tick();
        check("fast_k0", {1'b0, dbn2}, 2'b00);
        tick();
        check("fast_k1", {1'b0, dbn2}, 2'b00);
        tick();
        check("fast_k2_level", {1'b0, dbn2}, 2'b01);
        check("fast_k2_press", {1'b0, prs2}, 2'b01);
        check("fast_k2_release", {1'b0, rls2}, 2'b00);
        tick();
        check("fast_k3_press", {1'b0, prs2}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
